// File: rtl/trap_arbiter.sv
// Trap arbiter: collects virtualised trap sources and the system IRQ while the
// guest runs, raises NMI, and on the guest's next ISR fetch switches to host
// mode, latching the winning cause and flagging the address capture window.
// Handshake: clr_valid is a single-cycle strobe with no ready; it always takes
// effect on the clock edge where it is high (a same-cycle set of the same bit wins).
module trap_arbiter #(
   parameter int NUM_SRC     = 4,
   parameter int NMI_TIMEOUT = 255,
   localparam int CAUSE_W    = $clog2(NUM_SRC + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               m1_n,
   input  logic               irq_sys_n,
   input  logic [NUM_SRC-1:0] trap_req,
   input  logic [NUM_SRC-1:0] trap_mask,
   input  logic               new_isr,
   input  logic               last_isr_jmp,
   input  logic               virtual_enabled,
   input  logic               clr_valid,
   input  logic [CAUSE_W-1:0] clr_idx,
   output logic               trap_state,
   output logic               nmi_n,
   output logic               irq_n,
   output logic               capture_address,
   output logic [CAUSE_W-1:0] trap_cause,
   output logic               timeout_err
);

   // Watchdog counter is at least 8 and at most 16 bits wide.
   localparam int CNT_RAW = $clog2(NMI_TIMEOUT + 1);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
   localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W + 1)'(NMI_TIMEOUT);

   typedef enum logic {HOST = 1'b0, GUEST = 1'b1} state_t;

   state_t             state;
   state_t             state_nxt;
   logic               m1_q;
   logic               m1_fall;
   logic               m1_rise;
   logic [NUM_SRC:0]   pending;
   logic [NUM_SRC:0]   pending_nxt;
   logic [NUM_SRC:0]   set_mask;
   logic [NUM_SRC:0]   clr_mask;
   logic [NUM_SRC:0]   entry_mask;
   logic               any_pending;
   logic               entry;
   logic               irq_supress;
   logic [CAUSE_W-1:0] low_idx;
   logic [CNT_W-1:0]   nmi_cnt;
   logic [CNT_W:0]     nmi_cnt_inc;

   // Next-state, pending update and combinational outputs.
   always_comb begin
      m1_fall     = m1_q & ~m1_n;
      m1_rise     = ~m1_q & m1_n;
      any_pending = |pending;
      // Lowest set index wins, so IRQ (bit 0) has top priority.
      low_idx = '0;
      for (int i = NUM_SRC; i >= 0; i--) begin
         if (pending[i]) low_idx = CAUSE_W'(i);
      end
      entry      = (state == GUEST) & m1_fall & any_pending & new_isr;
      set_mask   = '0;
      clr_mask   = '0;
      entry_mask = '0;
      if (state == GUEST) begin
         set_mask[NUM_SRC:1] = trap_req & trap_mask;
         set_mask[0]         = ~irq_n & ~irq_supress;
      end
      // Out-of-range clr_idx matches no bit and is therefore ignored.
      for (int i = 0; i <= NUM_SRC; i++) begin
         clr_mask[i]   = clr_valid & (clr_idx == CAUSE_W'(i));
         entry_mask[i] = entry & (low_idx == CAUSE_W'(i));
      end
      pending_nxt = (pending & ~clr_mask & ~entry_mask) | set_mask;
      state_nxt = state;
      case (state)
         HOST:  if (m1_fall & virtual_enabled & last_isr_jmp) state_nxt = GUEST;
         GUEST: if (entry) state_nxt = HOST;
                else if (m1_fall & ~virtual_enabled) state_nxt = HOST;
         default: state_nxt = HOST;
      endcase
      trap_state  = (state == HOST);
      nmi_n       = ~((state == GUEST) & any_pending);
      nmi_cnt_inc = {1'b0, nmi_cnt} + (CNT_W + 1)'(1);
   end

   // M1 edge detection and IRQ latching on M1 rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         m1_q  <= 1'b1;
         irq_n <= 1'b1;
      end else begin
         m1_q <= m1_n;
         if (m1_rise) irq_n <= irq_sys_n;
      end
   end

   // Host/guest state register.
   always_ff @(posedge clk) begin
      if (rst) state <= HOST;
      else     state <= state_nxt;
   end

   // Pending bits, cause latch, capture window and IRQ suppression.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending         <= '0;
         trap_cause      <= '0;
         capture_address <= 1'b0;
         irq_supress     <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (entry) trap_cause <= low_idx;
         // Capture window opens on the entry M1 fall and closes on the next one.
         if (m1_fall) capture_address <= entry;
         if (irq_n) irq_supress <= 1'b0;
         else if (set_mask[0]) irq_supress <= 1'b1;
      end
   end

   // NMI watchdog: saturating low-time counter with a sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         nmi_cnt     <= '0;
         timeout_err <= 1'b0;
      end else if (nmi_n) begin
         nmi_cnt <= '0;
      end else begin
         if (nmi_cnt != '1) nmi_cnt <= nmi_cnt_inc[CNT_W-1:0];
         if (nmi_cnt_inc >= TIMEOUT_V) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_trap_arbiter.sv
// Bench for trap_arbiter: directed table, corner-case sequences and random
// stimulus, all checked against a behavioural model of the arbiter rules.
module tb_trap_arbiter;
   localparam int NS = 4;
   localparam int TO = 10;
   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic          m1_n;
   logic          irq_sys_n;
   logic [NS-1:0] trap_req;
   logic [NS-1:0] trap_mask;
   logic          new_isr;
   logic          last_isr_jmp;
   logic          virtual_enabled;
   logic          clr_valid;
   logic [CW-1:0] clr_idx;
   logic          trap_state;
   logic          nmi_n;
   logic          irq_n;
   logic          capture_address;
   logic [CW-1:0] trap_cause;
   logic          timeout_err;

   int n_vec = 0;
   int n_miss = 0;

   // Reference model state.
   bit          m_host;
   logic [NS:0] m_pend;
   int          m_cause;
   bit          m_cap;
   bit          m_irq;
   bit          m_sup;
   bit          m_m1q;
   bit          m_err;
   int          m_cnt;

   typedef struct {
      logic          rst;
      logic          m1_n;
      logic          ve;
      logic          lij;
      logic          ni;
      logic [NS-1:0] req;
      logic          e_state;
      logic          e_nmi;
      logic          e_cap;
      logic [CW-1:0] e_cause;
   } vec_t;
   vec_t tbl[8];

   trap_arbiter #(.NUM_SRC(NS), .NMI_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .m1_n(m1_n), .irq_sys_n(irq_sys_n),
      .trap_req(trap_req), .trap_mask(trap_mask), .new_isr(new_isr),
      .last_isr_jmp(last_isr_jmp), .virtual_enabled(virtual_enabled),
      .clr_valid(clr_valid), .clr_idx(clr_idx), .trap_state(trap_state),
      .nmi_n(nmi_n), .irq_n(irq_n), .capture_address(capture_address),
      .trap_cause(trap_cause), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_edge();
      bit          guest;
      bit          fall;
      bit          rise;
      bit          entry;
      int          low;
      logic [NS:0] np;
      if (rst) begin
         m_host = 1; m_pend = '0; m_cause = 0; m_cap = 0; m_irq = 1;
         m_sup = 0; m_m1q = 1; m_err = 0; m_cnt = 0;
      end else begin
         guest = !m_host;
         fall  = m_m1q && !m1_n;
         rise  = !m_m1q && m1_n;
         low   = -1;
         for (int i = 0; i <= NS; i++) if (m_pend[i] && low < 0) low = i;
         entry = guest && fall && (m_pend != 0) && new_isr;
         if (guest && m_pend != 0) begin
            if (m_cnt < 100000) m_cnt++;
            if (m_cnt >= TO) m_err = 1;
         end else begin
            m_cnt = 0;
         end
         np = m_pend;
         if (clr_valid && clr_idx <= NS) np[clr_idx] = 1'b0;
         if (entry) np[low] = 1'b0;
         if (guest) begin
            for (int k = 1; k <= NS; k++) if (trap_req[k-1] && trap_mask[k-1]) np[k] = 1'b1;
            if (!m_irq && !m_sup) np[0] = 1'b1;
         end
         if (m_irq) m_sup = 0;
         else if (guest) m_sup = 1;
         if (entry) begin
            m_host = 1; m_cause = low;
         end else if (fall && guest && !virtual_enabled) begin
            m_host = 1;
         end else if (fall && !guest && virtual_enabled && last_isr_jmp) begin
            m_host = 0;
         end
         if (fall) m_cap = entry;
         if (rise) m_irq = irq_sys_n;
         m_m1q = m1_n;
         m_pend = np;
      end
   endtask

   task automatic check_model();
      check("trap_state", trap_state, m_host);
      check("nmi_n", nmi_n, !(!m_host && m_pend != 0));
      check("irq_n", irq_n, m_irq);
      check("capture_address", capture_address, m_cap);
      check("trap_cause", trap_cause, m_cause);
      check("timeout_err", timeout_err, m_err);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic go_guest();
      virtual_enabled = 1; last_isr_jmp = 1; new_isr = 0;
      m1_n = 0; step();
      last_isr_jmp = 0;
      m1_n = 1; step();
   endtask

   task automatic take_entry();
      new_isr = 1; m1_n = 0; step();
      new_isr = 0; m1_n = 1; step();
   endtask

   initial begin
      rst = 1; m1_n = 1; irq_sys_n = 1; trap_req = '0; trap_mask = 4'hF;
      new_isr = 0; last_isr_jmp = 0; virtual_enabled = 0; clr_valid = 0; clr_idx = '0;

      // Boot: guest mode disabled, M1 toggling never leaves host.
      step();
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         m1_n = ~m1_n;
         last_isr_jmp = 1'(i % 2);
         step();
         check("boot_state", trap_state, 1);
         check("boot_nmi", nmi_n, 1);
      end
      last_isr_jmp = 0;

      // Directed entry table: source 2 raises trap, entry reports cause 3.
      tbl[0] = '{1, 1, 0, 0, 0, 4'b0000, 1, 1, 0, 3'd0};
      tbl[1] = '{0, 1, 1, 1, 0, 4'b0000, 1, 1, 0, 3'd0};
      tbl[2] = '{0, 0, 1, 1, 0, 4'b0000, 0, 1, 0, 3'd0};
      tbl[3] = '{0, 1, 1, 0, 0, 4'b0100, 0, 0, 0, 3'd0};
      tbl[4] = '{0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 3'd0};
      tbl[5] = '{0, 0, 1, 0, 1, 4'b0000, 1, 1, 1, 3'd3};
      tbl[6] = '{0, 1, 1, 0, 0, 4'b0000, 1, 1, 1, 3'd3};
      tbl[7] = '{0, 0, 1, 0, 0, 4'b0000, 1, 1, 0, 3'd3};
      for (int i = 0; i < 8; i++) begin
         rst = tbl[i].rst; m1_n = tbl[i].m1_n; virtual_enabled = tbl[i].ve;
         last_isr_jmp = tbl[i].lij; new_isr = tbl[i].ni; trap_req = tbl[i].req;
         step();
         check("tbl_state", trap_state, tbl[i].e_state);
         check("tbl_nmi", nmi_n, tbl[i].e_nmi);
         check("tbl_cap", capture_address, tbl[i].e_cap);
         check("tbl_cause", trap_cause, tbl[i].e_cause);
      end
      new_isr = 0; trap_req = '0;

      // Priority: IRQ beats source 3, then source 3 traps after return.
      m1_n = 1; step();
      go_guest();
      trap_req = 4'b1000; irq_sys_n = 0; m1_n = 0; step();
      m1_n = 1; step();
      trap_req = '0; step();
      take_entry();
      check("prio_first_cause", trap_cause, 0);
      irq_sys_n = 1; m1_n = 0; step();
      m1_n = 1; step();
      step();
      go_guest();
      check("prio_nmi_reassert", nmi_n, 0);
      take_entry();
      check("prio_second_cause", trap_cause, 4);

      // Mask and clear: masked source is ignored, set beats same-cycle clear.
      go_guest();
      trap_mask = 4'b1101; trap_req = 4'b0010;
      repeat (3) step();
      check("masked_no_nmi", nmi_n, 1);
      trap_mask = 4'hF; clr_valid = 1; clr_idx = 3'd2;
      step();
      check("set_beats_clear", nmi_n, 0);
      trap_req = '0; step();
      clr_valid = 0;
      check("clear_drops_nmi", nmi_n, 1);
      trap_req = 4'b0001; step();
      trap_req = '0; clr_valid = 1; clr_idx = 3'd5; step();
      clr_valid = 0;
      check("oob_clear_ignored", nmi_n, 0);
      clr_valid = 1; clr_idx = 3'd1; step();
      clr_valid = 0;
      check("clear_bit1", nmi_n, 1);

      // Watchdog: NMI held low for the timeout period.
      rst = 1; step();
      rst = 0;
      check("err_after_rst", timeout_err, 0);
      m1_n = 1; step();
      go_guest();
      trap_req = 4'b0001; step();
      trap_req = '0;
      repeat (TO - 1) step();
      check("err_before_timeout", timeout_err, 0);
      step();
      check("err_at_timeout", timeout_err, 1);
      rst = 1; step();
      rst = 0;
      check("err_cleared_by_rst", timeout_err, 0);
      check("rst_host", trap_state, 1);

      // IRQ suppression: one IRQ trap per low period of irq_n.
      m1_n = 1; step();
      go_guest();
      irq_sys_n = 0; m1_n = 0; step();
      m1_n = 1; step();
      step();
      check("irq_nmi", nmi_n, 0);
      take_entry();
      check("irq_cause", trap_cause, 0);
      go_guest();
      repeat (3) step();
      check("irq_suppressed", nmi_n, 1);
      irq_sys_n = 1; m1_n = 0; step();
      m1_n = 1; step();
      step();
      irq_sys_n = 0; m1_n = 0; step();
      m1_n = 1; step();
      step();
      check("irq_rearmed", nmi_n, 0);

      // Random stimulus against the model.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 2) == 0) m1_n = ~m1_n;
         if ($urandom_range(0, 7) == 0) irq_sys_n = ~irq_sys_n;
         trap_req = ($urandom_range(0, 3) == 0) ? NS'($urandom_range(0, 15)) : '0;
         trap_mask = ($urandom_range(0, 3) == 0) ? NS'($urandom_range(0, 15)) : 4'hF;
         new_isr = ($urandom_range(0, 1) == 0);
         last_isr_jmp = ($urandom_range(0, 2) == 0);
         virtual_enabled = ($urandom_range(0, 7) != 0);
         clr_valid = ($urandom_range(0, 5) == 0);
         clr_idx = CW'($urandom_range(0, 7));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
